qgemm_tile_reader: RTL and testbench

AXI read master that fetches a 2-D tile (num_row rows × num_col 32-bit words, rows separated by a byte stride) from the qgemm DRAM slave. It splits each row into INCR bursts of at most MAX_BURST_LEN beats, never crossing a 4 KB boundary. Returned data is forwarded on a valid/ready word stream with row-end and tile-end markers. It sits directly upstream of the DRAM AXI slave port (AR/R channels only) and feeds the GEMM operand buffers.

---
 rtl/qgemm_tile_reader_pkg.sv | 20 ++
 rtl/qgemm_burst_len_calc.sv | 38 +++
 rtl/qgemm_tile_reader.sv | 183 ++++++++++++++++++
 tb/tb_qgemm_tile_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qgemm_tile_reader_pkg.sv
// Shared types and AXI constants for the qgemm tile reader.
package qgemm_tile_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    localparam int AXI_ALEN_W   = 8;
    localparam int AXI_ASIZE_W  = 3;
    localparam int AXI_ABURST_W = 2;
    localparam int AXI_RRESP_W  = 2;

    localparam logic [AXI_ABURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_RRESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int                      AXI_PAGE_BYTES = 4096;

endpackage

// File: rtl/qgemm_burst_len_calc.sv
// Burst length = min(remaining words, MAX_BURST_LEN, words left in the 4 KB page).
module qgemm_burst_len_calc
    import qgemm_tile_reader_pkg::*;
#(
    parameter int BW_DATA       = 32,
    parameter int BW_DIM        = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]           page_off_i,
    input  logic [BW_DIM-1:0]     remaining_i,
    output logic [BW_DIM-1:0]     len_o,
    output logic [AXI_ALEN_W-1:0] alen_o
);

    localparam int LSB = $clog2(BW_DATA / 8);

    logic [12:0] bytes_to_page_s;
    logic [12:0] words_to_page_s;
    logic [12:0] cap_s;

    // Three-way minimum; the page term is at least one word for an aligned address.
    always_comb begin
        bytes_to_page_s = 13'(AXI_PAGE_BYTES) - {1'b0, page_off_i};
        words_to_page_s = bytes_to_page_s >> LSB;
        if (words_to_page_s > 13'(MAX_BURST_LEN)) begin
            cap_s = 13'(MAX_BURST_LEN);
        end else begin
            cap_s = words_to_page_s;
        end
        if (remaining_i < BW_DIM'(cap_s)) begin
            len_o = remaining_i;
        end else begin
            len_o = BW_DIM'(cap_s);
        end
        alen_o = AXI_ALEN_W'(len_o - BW_DIM'(1));
    end

endmodule

// File: rtl/qgemm_tile_reader.sv
// AXI read master fetching a strided 2-D tile and streaming it out word by word.
module qgemm_tile_reader
    import qgemm_tile_reader_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_AXI_TID    = 16,
    parameter int AXI_TID       = 0,
    parameter int MAX_BURST_LEN = 16,
    parameter int BW_DIM        = 16
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [BW_ADDR-1:0]      cfg_base_addr,
    input  logic [BW_ADDR-1:0]      cfg_stride,
    input  logic [BW_DIM-1:0]       cfg_num_row,
    input  logic [BW_DIM-1:0]       cfg_num_col,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [BW_AXI_TID-1:0]   sxarid,
    output logic [BW_ADDR-1:0]      sxaraddr,
    output logic [AXI_ALEN_W-1:0]   sxarlen,
    output logic [AXI_ASIZE_W-1:0]  sxarsize,
    output logic [AXI_ABURST_W-1:0] sxarburst,
    output logic                    sxarvalid,
    input  logic                    sxarready,
    input  logic [BW_AXI_TID-1:0]   sxrid,
    input  logic [BW_DATA-1:0]      sxrdata,
    input  logic [AXI_RRESP_W-1:0]  sxrresp,
    input  logic                    sxrlast,
    input  logic                    sxrvalid,
    output logic                    sxrready,
    output logic [BW_DATA-1:0]      odata,
    output logic                    ovalid,
    input  logic                    oready,
    output logic                    olast_row,
    output logic                    olast
);

    localparam int                 BYTES     = BW_DATA / 8;
    localparam int                 LSB       = $clog2(BYTES);
    localparam logic [BW_ADDR-1:0] ADDR_MASK = ~BW_ADDR'(BYTES - 1);

    rd_state_e             state_q;
    logic [BW_ADDR-1:0]    row_addr_q, stride_q, sxaraddr_q;
    logic [BW_DIM-1:0]     num_col_q, row_rem_q, col_rem_q, beat_q, burst_len_q;
    logic [AXI_ALEN_W-1:0] sxarlen_q;
    logic                  error_q;

    logic                  beat_hs_s, last_beat_s, row_end_s, tile_end_s, resp_bad_s;
    logic [BW_DIM-1:0]     col_left_s, nxt_rem_s, nxt_len_s;
    logic [BW_ADDR-1:0]    nxt_addr_s;
    logic [AXI_ALEN_W-1:0] nxt_alen_s;

    assign beat_hs_s   = (state_q == ST_DATA) & sxrvalid & oready;
    assign last_beat_s = (beat_q == burst_len_q - BW_DIM'(1));
    assign col_left_s  = col_rem_q - burst_len_q;
    assign row_end_s   = last_beat_s & (col_left_s == BW_DIM'(0));
    assign tile_end_s  = row_end_s & (row_rem_q == BW_DIM'(1));
    assign resp_bad_s  = (sxrresp != AXI_RESP_OKAY) | (sxrlast != last_beat_s)
                       | (sxrid != BW_AXI_TID'(AXI_TID));

    // Start of the next burst: tile origin, continuation within the row, or next row.
    always_comb begin
        nxt_addr_s = row_addr_q + stride_q;
        nxt_rem_s  = num_col_q;
        if (state_q == ST_IDLE) begin
            nxt_addr_s = cfg_base_addr & ADDR_MASK;
            nxt_rem_s  = cfg_num_col;
        end else if (col_left_s != BW_DIM'(0)) begin
            nxt_addr_s = sxaraddr_q + (BW_ADDR'(burst_len_q) << LSB);
            nxt_rem_s  = col_left_s;
        end else begin
            nxt_addr_s = row_addr_q + stride_q;
            nxt_rem_s  = num_col_q;
        end
    end

    qgemm_burst_len_calc #(
        .BW_DATA       (BW_DATA),
        .BW_DIM        (BW_DIM),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .page_off_i  (nxt_addr_s[11:0]),
        .remaining_i (nxt_rem_s),
        .len_o       (nxt_len_s),
        .alen_o      (nxt_alen_s)
    );

    // Control FSM with tile/row/burst bookkeeping; one burst in flight at a time.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= ST_IDLE;
            row_addr_q  <= '0;
            stride_q    <= '0;
            sxaraddr_q  <= '0;
            num_col_q   <= '0;
            row_rem_q   <= '0;
            col_rem_q   <= '0;
            beat_q      <= '0;
            burst_len_q <= '0;
            sxarlen_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        error_q    <= 1'b0;
                        row_addr_q <= cfg_base_addr & ADDR_MASK;
                        stride_q   <= cfg_stride & ADDR_MASK;
                        num_col_q  <= cfg_num_col;
                        row_rem_q  <= cfg_num_row;
                        beat_q     <= '0;
                        if (cfg_num_row == BW_DIM'(0) || cfg_num_col == BW_DIM'(0)) begin
                            state_q <= ST_DONE;
                        end else begin
                            sxaraddr_q  <= nxt_addr_s;
                            sxarlen_q   <= nxt_alen_s;
                            burst_len_q <= nxt_len_s;
                            col_rem_q   <= nxt_rem_s;
                            state_q     <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sxarready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_hs_s) begin
                        if (resp_bad_s) begin
                            error_q <= 1'b1;
                        end
                        if (!last_beat_s) begin
                            beat_q <= beat_q + BW_DIM'(1);
                        end else if (tile_end_s) begin
                            beat_q  <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            beat_q      <= '0;
                            sxaraddr_q  <= nxt_addr_s;
                            sxarlen_q   <= nxt_alen_s;
                            burst_len_q <= nxt_len_s;
                            col_rem_q   <= nxt_rem_s;
                            state_q     <= ST_ADDR;
                            if (row_end_s) begin
                                row_addr_q <= nxt_addr_s;
                                row_rem_q  <= row_rem_q - BW_DIM'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign sxarid      = BW_AXI_TID'(AXI_TID);
    assign sxaraddr    = sxaraddr_q;
    assign sxarlen     = sxarlen_q;
    assign sxarsize    = AXI_ASIZE_W'(LSB);
    assign sxarburst   = AXI_BURST_INCR;
    assign sxarvalid   = (state_q == ST_ADDR);
    assign sxrready    = (state_q == ST_DATA) & oready;
    assign ovalid      = (state_q == ST_DATA) & sxrvalid;
    assign odata       = sxrdata;
    assign olast_row   = ovalid & row_end_s;
    assign olast       = ovalid & tile_end_s;

endmodule

// File: tb/tb_qgemm_tile_reader.sv
// Directed bench for qgemm_tile_reader with a reactive AXI slave and a transaction-level model.
module tb_qgemm_tile_reader;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        start_valid, start_ready, busy, done, error;
    logic [31:0] cfg_base_addr, cfg_stride;
    logic [15:0] cfg_num_row, cfg_num_col;
    logic [15:0] sxarid, sxrid;
    logic [31:0] sxaraddr, sxrdata, odata;
    logic [7:0]  sxarlen;
    logic [2:0]  sxarsize;
    logic [1:0]  sxarburst, sxrresp;
    logic        sxarvalid, sxarready, sxrlast, sxrvalid, sxrready;
    logic        ovalid, oready, olast_row, olast;

    always #5 clk = ~clk;

    qgemm_tile_reader dut (
        .clk(clk), .rstnn(rstnn), .start_valid(start_valid), .start_ready(start_ready),
        .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride), .cfg_num_row(cfg_num_row),
        .cfg_num_col(cfg_num_col), .busy(busy), .done(done), .error(error),
        .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
        .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
        .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
        .sxrvalid(sxrvalid), .sxrready(sxrready), .odata(odata), .ovalid(ovalid),
        .oready(oready), .olast_row(olast_row), .olast(olast)
    );

    typedef enum int {P_IDLE, P_AR, P_DATA, P_DONE} phase_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    phase_t      phase;
    logic        exp_err;
    logic [31:0] ar_q_addr[$];
    logic [7:0]  ar_q_len[$];
    logic [31:0] w_data[$];
    logic        w_lrow[$];
    logic        w_last[$];
    logic [31:0] got_addr[$];
    int          got_len[$];
    bit          sl_active, rv_pend, ar_block;
    logic [31:0] sl_addr;
    int          sl_len, sl_beat, g_beat, err_beat, rnd_mode;
    logic [31:0] t_base, t_stride;
    logic [15:0] t_rows, t_cols;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected AR sequence and word stream from plain address arithmetic.
    task automatic plan(input logic [31:0] base, input logic [31:0] stride, input int rows, input int cols);
        logic [31:0] a;
        int rem, room, len;
        for (int r = 0; r < rows; r++) begin
            a   = (base & ~32'h3) + 32'(r) * (stride & ~32'h3);
            rem = cols;
            while (rem > 0) begin
                room = (4096 - int'(a[11:0])) / 4;
                len  = rem;
                if (len > 16) len = 16;
                if (len > room) len = room;
                ar_q_addr.push_back(a);
                ar_q_len.push_back(8'(len - 1));
                for (int i = 0; i < len; i++) begin
                    w_data.push_back(dat(a + 32'(4 * i)));
                    w_lrow.push_back((i == len - 1) && (rem == len));
                    w_last.push_back((i == len - 1) && (rem == len) && (r == rows - 1));
                end
                a   = a + 32'(4 * len);
                rem = rem - len;
            end
        end
    endtask

    // One clock: drive at the falling edge, compare, then account for the coming rising edge.
    task automatic step(input bit sv);
        bit ar_hs, r_hs, blast;
        @(negedge clk);
        start_valid = sv;
        if (sv) begin
            cfg_base_addr = t_base; cfg_stride = t_stride;
            cfg_num_row = t_rows; cfg_num_col = t_cols;
        end else begin
            cfg_base_addr = $urandom; cfg_stride = $urandom;
            cfg_num_row = 16'($urandom); cfg_num_col = 16'($urandom);
        end
        if (sl_active) begin
            if (!rv_pend) rv_pend = (rnd_mode == 0) || ($urandom_range(0, 2) != 0);
        end else begin
            rv_pend = 1'b0;
        end
        sxrvalid  = rv_pend;
        sxrdata   = dat(sl_addr + 32'(sl_beat * 4));
        sxrlast   = (sl_beat == sl_len);
        sxrresp   = (g_beat == err_beat) ? 2'b10 : 2'b00;
        sxrid     = 16'h0000;
        sxarready = ar_block ? 1'b0 : ((rnd_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        oready    = (rnd_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        chk("start_ready", start_ready, phase == P_IDLE);
        chk("busy", busy, phase != P_IDLE);
        chk("done", done, phase == P_DONE);
        chk("error", error, exp_err);
        chk("arvalid", sxarvalid, phase == P_AR);
        chk("rready", sxrready, (phase == P_DATA) && oready);
        chk("ovalid", ovalid, (phase == P_DATA) && sxrvalid);
        if (phase == P_AR && ar_q_addr.size() > 0) begin
            chk("araddr", sxaraddr, ar_q_addr[0]);
            chk("arlen", sxarlen, ar_q_len[0]);
        end
        ar_hs = sxarvalid && sxarready;
        r_hs  = sxrvalid && sxrready;
        blast = r_hs && (sl_beat == sl_len);
        if (r_hs) begin
            if (w_data.size() == 0) begin
                chk("extra_word", 1'b1, 1'b0);
            end else begin
                chk("odata", odata, w_data.pop_front());
                chk("olast_row", olast_row, w_lrow.pop_front());
                chk("olast", olast, w_last.pop_front());
            end
            if (g_beat == err_beat) exp_err = 1'b1;
            g_beat++;
            rv_pend = 1'b0;
            if (blast) sl_active = 1'b0;
            else sl_beat++;
        end
        if (ar_hs) begin
            chk("arsize", sxarsize, 3'd2);
            chk("arburst", sxarburst, 2'b01);
            chk("arid", sxarid, 16'h0000);
            got_addr.push_back(sxaraddr);
            got_len.push_back(int'(sxarlen));
            if (ar_q_addr.size() > 0) begin
                void'(ar_q_addr.pop_front());
                void'(ar_q_len.pop_front());
            end
            sl_active = 1'b1; sl_addr = sxaraddr; sl_len = int'(sxarlen); sl_beat = 0;
        end
        case (phase)
            P_IDLE: if (sv) begin
                exp_err = 1'b0;
                phase   = (t_rows == 16'd0 || t_cols == 16'd0) ? P_DONE : P_AR;
            end
            P_AR:   if (ar_hs) phase = P_DATA;
            P_DATA: if (blast) phase = (ar_q_addr.size() > 0) ? P_AR : P_DONE;
            P_DONE: phase = P_IDLE;
            default: phase = P_IDLE;
        endcase
    endtask

    task automatic run_tile(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] rows,
                            input logic [15:0] cols, input int mode, input int eb);
        t_base = base; t_stride = stride; t_rows = rows; t_cols = cols;
        rnd_mode = mode; err_beat = eb; g_beat = 0;
        got_addr.delete(); got_len.delete();
        plan(base, stride, int'(rows), int'(cols));
        step(1'b1);
        for (int c = 0; c < 3000 && phase != P_IDLE; c++) step(1'b0);
        if (phase != P_IDLE) chk("tile_timeout", 1'b0, 1'b1);
        chk("words_left", w_data.size(), 0);
        chk("ars_left", ar_q_addr.size(), 0);
        step(1'b0);
    endtask

    initial begin
        rstnn = 1'b0; start_valid = 1'b0; oready = 1'b0;
        cfg_base_addr = 32'h0; cfg_stride = 32'h0; cfg_num_row = 16'h0; cfg_num_col = 16'h0;
        sxarready = 1'b0; sxrvalid = 1'b0; sxrid = 16'h0; sxrdata = 32'h0;
        sxrresp = 2'b00; sxrlast = 1'b0;
        phase = P_IDLE; exp_err = 1'b0; sl_active = 1'b0; rv_pend = 1'b0; ar_block = 1'b0;
        sl_addr = 32'h0; sl_len = 0; sl_beat = 0; g_beat = 0; err_beat = -1; rnd_mode = 0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_araddr", sxaraddr, 32'h0);
        chk("rst_arlen", sxarlen, 8'h0);
        chk("rst_arsize", sxarsize, 3'd2);
        chk("rst_arburst", sxarburst, 2'b01);
        chk("rst_olast", {olast, olast_row, ovalid, error, done, sxarvalid, sxrready}, 7'b0);
        rstnn = 1'b1;
        step(1'b0);

        run_tile(32'h100, 32'h0, 16'd1, 16'd4, 0, -1);
        chk("t1_n_ar", got_addr.size(), 1);
        chk("t1_ar0", {got_addr[0], 8'(got_len[0])}, {32'h100, 8'd3});

        run_tile(32'h0, 32'h0, 16'd1, 16'd40, 0, -1);
        chk("t2_n_ar", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            chk("t2_ar0", {got_addr[0], 8'(got_len[0])}, {32'h000, 8'd15});
            chk("t2_ar1", {got_addr[1], 8'(got_len[1])}, {32'h040, 8'd15});
            chk("t2_ar2", {got_addr[2], 8'(got_len[2])}, {32'h080, 8'd7});
        end

        run_tile(32'hFF8, 32'h0, 16'd1, 16'd6, 0, -1);
        chk("t3_n_ar", got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            chk("t3_ar0", {got_addr[0], 8'(got_len[0])}, {32'hFF8, 8'd1});
            chk("t3_ar1", {got_addr[1], 8'(got_len[1])}, {32'h1000, 8'd3});
        end

        run_tile(32'h1000, 32'h200, 16'd3, 16'd2, 0, -1);
        chk("t4_n_ar", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            chk("t4_ar0", {got_addr[0], 8'(got_len[0])}, {32'h1000, 8'd1});
            chk("t4_ar1", {got_addr[1], 8'(got_len[1])}, {32'h1200, 8'd1});
            chk("t4_ar2", {got_addr[2], 8'(got_len[2])}, {32'h1400, 8'd1});
        end

        run_tile(32'h2000, 32'h0, 16'd1, 16'd16, 1, 4);
        chk("t5_error_sticky", error, 1'b1);
        chk("t5_n_ar", got_addr.size(), 1);
        repeat (3) step(1'b0);

        run_tile(32'h3004, 32'h10, 16'd2, 16'd3, 0, -1);
        chk("t6_error_cleared", error, 1'b0);

        run_tile(32'h500, 32'h4, 16'd0, 16'd5, 0, -1);
        chk("t7_no_ar", got_addr.size(), 0);
        run_tile(32'h500, 32'h4, 16'd2, 16'd0, 0, -1);
        chk("t8_no_ar", got_addr.size(), 0);

        // Reset while the address phase is stalled.
        ar_block = 1'b1; rnd_mode = 0; g_beat = 0; err_beat = -1;
        t_base = 32'h700; t_stride = 32'h0; t_rows = 16'd1; t_cols = 16'd4;
        plan(t_base, t_stride, 1, 4);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        rstnn = 1'b0;
        #1;
        chk("arst_arvalid", sxarvalid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_start_ready", start_ready, 1'b1);
        chk("arst_rready", sxrready, 1'b0);
        phase = P_IDLE; exp_err = 1'b0; sl_active = 1'b0; rv_pend = 1'b0; ar_block = 1'b0;
        ar_q_addr.delete(); ar_q_len.delete(); w_data.delete(); w_lrow.delete(); w_last.delete();
        @(negedge clk);
        rstnn = 1'b1;
        step(1'b0);

        run_tile(32'hFC0, 32'h1000, 16'd2, 16'd20, 1, -1);
        chk("t9_n_ar", got_addr.size(), 4);
        if (got_addr.size() == 4) begin
            chk("t9_ar0", {got_addr[0], 8'(got_len[0])}, {32'hFC0, 8'd15});
            chk("t9_ar1", {got_addr[1], 8'(got_len[1])}, {32'h1000, 8'd3});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
